dc_nb_timer: RTL and testbench

- Parametrised N-bit down-counter/timer; the next generation of the team's 2-bit loadable down counter.
- Adds programmable width, a reload register, one-shot/periodic modes, a start/stop control FSM and a registered terminal-count pulse.
- Sits beside control FSMs as a delay, timeout or periodic-tick source.

---
 rtl/dc_nb_pkg.sv | 18 +
 rtl/dc_nb_prescaler.sv | 31 +++
 rtl/dc_nb_timer.sv | 126 ++++++++++++
 tb/tb_dc_nb_timer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_nb_pkg.sv
// Shared types and default parameters for the dc_nb_timer down-counter/timer.
package dc_nb_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_PRESCALE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_t;

endpackage

// File: rtl/dc_nb_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the last enabled cycle of each period.
module dc_nb_prescaler
    import dc_nb_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/dc_nb_timer.sv
// Parametrised loadable down-counter/timer with reload, one-shot/periodic modes and tc pulse.
// Define DC_NB_PRESCALE_EN to divide count ticks by PRESCALE enabled cycles.
module dc_nb_timer
    import dc_nb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    mode_t            mode_s;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload_nxt;
    logic             tc_nxt;
    logic             tick;
    logic             run_tick;
    logic             reload_is_zero;

    assign mode_s         = mode_t'(mode);
    assign run_tick       = (state == RUN) && tick;
    assign reload_is_zero = (reload == '0);

`ifdef DC_NB_PRESCALE_EN
    logic presc_clear;

    // Phase restarts on any control action and when the timer lands in DONE.
    assign presc_clear = load || stop || start || ((state_nxt == DONE) && (state != DONE));

    dc_nb_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (enable && (state == RUN)),
        .tick   (tick)
    );
`else
    logic unused_prescale;

    assign tick            = enable;
    assign unused_prescale = (PRESCALE != 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority: load > stop > start > tick; stop suppresses a simultaneous start.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else if (stop) begin
            if (state == RUN) begin
                state_nxt = IDLE;
            end
        end else if (start) begin
            state_nxt = reload_is_zero ? DONE : RUN;
        end else if (run_tick && (mode_s == ONE_SHOT)) begin
            if ((count == WIDTH'(1)) || (count == '0)) begin
                state_nxt = DONE;
            end
        end
    end

    always_comb begin
        count_nxt  = count;
        reload_nxt = reload;
        tc_nxt     = 1'b0;
        if (load) begin
            count_nxt  = data;
            reload_nxt = data;
        end else if (stop) begin
            count_nxt = count;
        end else if (start) begin
            count_nxt = reload;
            tc_nxt    = reload_is_zero;
        end else if (run_tick) begin
            if (count > WIDTH'(1)) begin
                count_nxt = count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
            end else if (mode_s == PERIODIC) begin
                count_nxt = reload;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '1;
            reload <= '1;
            tc     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            count  <= count_nxt;
            reload <= reload_nxt;
            tc     <= tc_nxt;
            busy   <= (state_nxt == RUN);
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_dc_nb_timer.sv
// Self-checking bench for dc_nb_timer: directed scenarios plus randomized control traffic
// compared every cycle against a behavioural model of the timer rules.
module tb_dc_nb_timer;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PRESCALE = 4;
    localparam int          MAXV     = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             mode;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             busy;

    dc_nb_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .data   (data),
        .mode   (mode),
        .start  (start),
        .stop   (stop),
        .count  (count),
        .zero   (zero),
        .tc     (tc),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: running flag, finished flag, count, reload, tc, prescale phase.
    bit m_running;
    bit m_finished;
    int m_count;
    int m_reload;
    bit m_tc;
    int m_phase;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running  = 1'b0;
        m_finished = 1'b0;
        m_count    = MAXV;
        m_reload   = MAXV;
        m_tc       = 1'b0;
        m_phase    = 0;
    endtask

    // Apply the timer rules for one rising edge using the currently driven inputs.
    task automatic model_step();
        bit ticked;
        m_tc = 1'b0;
        if (load) begin
            m_count    = int'(data);
            m_reload   = int'(data);
            m_running  = 1'b0;
            m_finished = 1'b0;
            m_phase    = 0;
        end else if (stop) begin
            if (m_running) m_running = 1'b0;
            m_phase = 0;
        end else if (start) begin
            m_count = m_reload;
            m_phase = 0;
            if (m_reload == 0) begin
                m_running  = 1'b0;
                m_finished = 1'b1;
                m_tc       = 1'b1;
            end else begin
                m_running  = 1'b1;
                m_finished = 1'b0;
            end
        end else if (m_running && enable) begin
            ticked = 1'b1;
`ifdef DC_NB_PRESCALE_EN
            if (m_phase == PRESCALE - 1) begin
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
                ticked  = 1'b0;
            end
`endif
            if (ticked) begin
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else if (m_count == 1) begin
                    m_count = 0;
                    m_tc    = 1'b1;
                    if (!mode) begin
                        m_running  = 1'b0;
                        m_finished = 1'b1;
                        m_phase    = 0;
                    end
                end else if (mode) begin
                    m_count = m_reload;
                end else begin
                    m_running  = 1'b0;
                    m_finished = 1'b1;
                    m_phase    = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".tc"},    32'(tc),    32'(m_tc));
        check({tag, ".busy"},  32'(busy),  32'(m_running));
        check({tag, ".zero"},  32'(zero),  32'(m_count == 0));
    endtask

    // One clock: model the edge, then sample DUT 1ns after it.
    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_load(input int v, input bit md);
        idle_inputs();
        load = 1'b1;
        data = WIDTH'(v);
        mode = md;
        cyc("load");
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc("start");
        start = 1'b0;
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("async_reset");
        check("async_reset.count_ff", 32'(count), 32'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int pulses;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        data   = '0;
        mode   = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;

        // One-shot from 3.
        do_load(3, 1'b0);
        do_start();
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            cyc("oneshot");
            if (tc) pulses++;
        end
        check("oneshot.pulses", 32'(pulses), 32'd1);
        check("oneshot.final_count", 32'(count), 32'd0);
        check("oneshot.busy", 32'(busy), 32'd0);

        // Periodic reload 2, 12 enabled cycles.
        do_load(2, 1'b1);
        do_start();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("periodic");
            if (tc) pulses++;
        end
`ifndef DC_NB_PRESCALE_EN
        check("periodic.pulses", 32'(pulses), 32'd4);
        check("periodic.busy", 32'(busy), 32'd1);
`endif

        // load beats start while running at count 7.
        do_load(9, 1'b0);
        do_start();
        while (m_count != 7 && m_running) cyc("run_to_7");
        load  = 1'b1;
        start = 1'b1;
        data  = WIDTH'(5);
        cyc("load_vs_start");
        idle_inputs();
        check("load_vs_start.count", 32'(count), 32'd5);
        check("load_vs_start.busy", 32'(busy), 32'd0);

        // stop beats start in RUN; count holds.
        do_start();
        cyc("pre_stop");
        stop  = 1'b1;
        start = 1'b1;
        cyc("stop_vs_start");
        idle_inputs();
        repeat (3) cyc("stopped_hold");

        // Zero reload: immediate DONE with a single tc, both modes.
        for (int md = 0; md < 2; md++) begin
            do_load(0, md[0]);
            do_start();
            check("zero_start.tc", 32'(tc), 32'd1);
            repeat (3) cyc("zero_done");
        end

        // Enable toggling in RUN.
        do_load(6, 1'b0);
        do_start();
        for (int i = 0; i < 16; i++) begin
            enable = i[0];
            cyc("en_toggle");
        end
        enable = 1'b1;

        // Asynchronous reset mid-run.
        do_load(20, 1'b1);
        do_start();
        repeat (4) cyc("pre_reset");
        async_reset_check();

        // Randomized control traffic.
        for (int i = 0; i < 4000; i++) begin
            load   = ($urandom % 20) == 0;
            start  = ($urandom % 12) == 0;
            stop   = ($urandom % 16) == 0;
            enable = ($urandom % 4) != 0;
            if (($urandom % 50) == 0) mode = ~mode;
            data   = (($urandom % 8) == 0) ? WIDTH'($urandom) : WIDTH'($urandom % 6);
            if (($urandom % 700) == 0) begin
                idle_inputs();
                async_reset_check();
            end else begin
                cyc("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
